game_ctrl: RTL and testbench

Game-state controller for the dinosaur runner. It is the source of game_status for the jump and obstacle stages. It consumes the dinosaur pixel stream and the obstacle pixel stream from the VGA scan to detect collisions. It also maintains the BCD running score and the high score for the score display stage.

---
 rtl/game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game-state controller for the dinosaur runner: run/over state,
// collision detection from pixel overlap, BCD score and high score.
module game_ctrl #(
  parameter int SCORE_DIV  = 6,
  parameter int HIT_THRESH = 4
) (
  input  logic        clkdiv,
  input  logic        RESET,
  input  logic        START,
  input  logic        fresh,
  input  logic        video_on,
  input  logic        dino_px,
  input  logic        obst_px,
  output logic        game_status,
  output logic        game_over,
  output logic        hit,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  localparam int FW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [FW-1:0] FC_LAST = FW'(SCORE_DIV - 1);
  localparam logic [7:0] THRESH = 8'(HIT_THRESH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            s1;
  logic            s2;
  logic            s3;
  logic            fresh_d;
  logic            start_pulse;
  logic            frame_tick;
  logic            overlap;
  logic            wrap;
  logic [7:0]      ovl_cnt;
  logic [7:0]      ovl_n;
  logic [FW-1:0]   frame_cnt;
  logic [FW-1:0]   frame_n;
  logic [15:0]     score_n;
  logic [15:0]     hi_n;
  logic            status_n;
  logic            over_n;
  logic            hit_n;

  // Add one to a 4-digit BCD value, holding at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // START synchronizer plus edge-detect delay, and frame strobe delay.
  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      fresh_d <= 1'b0;
    end else begin
      s1      <= START;
      s2      <= s1;
      s3      <= s2;
      fresh_d <= fresh;
    end
  end

  assign start_pulse = s2 & ~s3;
  assign frame_tick  = fresh_d & ~fresh;
  assign overlap     = video_on & dino_px & obst_px;
  assign wrap        = (frame_cnt == FC_LAST);

  // Next-state, counter and score update logic.
  always_comb begin
    state_n = state;
    ovl_n   = ovl_cnt;
    frame_n = frame_cnt;
    score_n = score;
    hi_n    = hi_score;
    hit_n   = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (start_pulse) begin
          state_n = RUN;
          ovl_n   = 8'd0;
          frame_n = '0;
          score_n = 16'h0000;
        end
      end
      RUN: begin
        if (frame_tick) begin
          ovl_n = 8'd0;
          if (ovl_cnt >= THRESH) begin
            state_n = OVER;
            hit_n   = 1'b1;
            if (score > hi_score) begin
              hi_n = score;
            end
          end else if (wrap) begin
            frame_n = '0;
            score_n = bcd_inc(score);
          end else begin
            frame_n = frame_cnt + 1'b1;
          end
        end else if (overlap && (ovl_cnt != 8'hFF)) begin
          ovl_n = ovl_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        ovl_n   = 8'd0;
      end
    endcase
    status_n = (state_n == RUN);
    over_n   = (state_n == OVER);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      ovl_cnt     <= 8'd0;
      frame_cnt   <= '0;
      score       <= 16'h0000;
      hi_score    <= 16'h0000;
      game_status <= 1'b0;
      game_over   <= 1'b0;
      hit         <= 1'b0;
    end else begin
      state       <= state_n;
      ovl_cnt     <= ovl_n;
      frame_cnt   <= frame_n;
      score       <= score_n;
      hi_score    <= hi_n;
      game_status <= status_n;
      game_over   <= over_n;
      hit         <= hit_n;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: two instances (SCORE_DIV 4 and 1) share stimulus;
// a behavioural model is compared every cycle, plus literal checkpoints.
module tb_game_ctrl;

  logic        clkdiv;
  logic        RESET;
  logic        START;
  logic        fresh;
  logic        video_on;
  logic        dino_px;
  logic        obst_px;
  logic        gs_a;
  logic        go_a;
  logic        hit_a;
  logic [15:0] score_a;
  logic [15:0] hi_a;
  logic        gs_b;
  logic        go_b;
  logic        hit_b;
  logic [15:0] score_b;
  logic [15:0] hi_b;

  int checks = 0;
  int errors = 0;

  game_ctrl #(.SCORE_DIV(4), .HIT_THRESH(4)) dut_a (
    .clkdiv(clkdiv), .RESET(RESET), .START(START), .fresh(fresh),
    .video_on(video_on), .dino_px(dino_px), .obst_px(obst_px),
    .game_status(gs_a), .game_over(go_a), .hit(hit_a),
    .score(score_a), .hi_score(hi_a)
  );

  game_ctrl #(.SCORE_DIV(1), .HIT_THRESH(4)) dut_b (
    .clkdiv(clkdiv), .RESET(RESET), .START(START), .fresh(fresh),
    .video_on(video_on), .dino_px(dino_px), .obst_px(obst_px),
    .game_status(gs_b), .game_over(go_b), .hit(hit_b),
    .score(score_b), .hi_score(hi_b)
  );

  initial clkdiv = 1'b0;
  always #5 clkdiv = ~clkdiv;

  // Model: mode 0 idle, 1 running, 2 over; scores kept as plain integers.
  typedef struct {
    int mode;
    int score;
    int hi;
    int fc;
    int ovl;
    int hit;
  } mst_t;

  mst_t       m [2];
  logic [2:0] hist;
  logic       fresh_prev;

  function automatic mst_t step(mst_t s, int div, bit tick, bit sp, bit ov);
    mst_t r;
    r = s;
    r.hit = 0;
    if (s.mode != 1) begin
      if (sp) begin
        r.mode = 1;
        r.score = 0;
        r.fc = 0;
        r.ovl = 0;
      end
    end else if (tick) begin
      r.ovl = 0;
      if (s.ovl >= 4) begin
        r.mode = 2;
        r.hit = 1;
        if (s.score > s.hi) r.hi = s.score;
      end else begin
        r.fc = s.fc + 1;
        if (r.fc == div) begin
          r.fc = 0;
          if (s.score < 9999) r.score = s.score + 1;
        end
      end
    end else if (ov && s.ovl < 255) begin
      r.ovl = s.ovl + 1;
    end
    return r;
  endfunction

  function automatic int bcd(int n);
    return ((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256
         + ((n / 10) % 10) * 16 + (n % 10);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advances on the same edges and reset as the design.
  always @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
      hist <= 3'b000;
      fresh_prev <= 1'b0;
    end else begin
      m[0] <= step(m[0], 4, fresh_prev & ~fresh, hist[1] & ~hist[2],
                   video_on & dino_px & obst_px);
      m[1] <= step(m[1], 1, fresh_prev & ~fresh, hist[1] & ~hist[2],
                   video_on & dino_px & obst_px);
      hist <= {hist[1:0], START};
      fresh_prev <= fresh;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clkdiv) begin
    chk("status_a", int'(gs_a), int'(m[0].mode == 1));
    chk("over_a", int'(go_a), int'(m[0].mode == 2));
    chk("hit_a", int'(hit_a), m[0].hit);
    chk("score_a", int'(score_a), bcd(m[0].score));
    chk("hi_a", int'(hi_a), bcd(m[0].hi));
    chk("status_b", int'(gs_b), int'(m[1].mode == 1));
    chk("over_b", int'(go_b), int'(m[1].mode == 2));
    chk("hit_b", int'(hit_b), m[1].hit);
    chk("score_b", int'(score_b), bcd(m[1].score));
    chk("hi_b", int'(hi_b), bcd(m[1].hi));
  end

  // One frame: n overlap cycles, then the falling edge of fresh.
  task automatic frame(int n, bit vid, bit on_tick);
    @(negedge clkdiv);
    fresh = 1'b1;
    video_on = 1'b0;
    dino_px = 1'b0;
    obst_px = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clkdiv);
      video_on = vid;
      dino_px = 1'b1;
      obst_px = 1'b1;
    end
    @(negedge clkdiv);
    fresh = 1'b0;
    video_on = on_tick;
    dino_px = on_tick;
    obst_px = on_tick;
  endtask

  task automatic frames(int k);
    for (int i = 0; i < k; i++) frame(0, 1'b1, 1'b0);
  endtask

  task automatic settle();
    @(posedge clkdiv);
    #1;
  endtask

  task automatic press();
    @(negedge clkdiv);
    START = 1'b1;
    repeat (4) @(negedge clkdiv);
    START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    fresh = 1'b0;
    video_on = 1'b0;
    dino_px = 1'b0;
    obst_px = 1'b0;
    repeat (3) @(negedge clkdiv);
    RESET = 1'b0;
    @(negedge clkdiv);
    chk("lit_reset_status", int'(gs_a), 0);
    chk("lit_reset_score", int'(score_a), 0);

    // Start latency: RUN on the third edge after START rises.
    @(negedge clkdiv);
    START = 1'b1;
    settle();
    chk("lit_lat_e1", int'(gs_a), 0);
    settle();
    chk("lit_lat_e2", int'(gs_a), 0);
    settle();
    chk("lit_lat_e3", int'(gs_a), 1);
    repeat (50) @(negedge clkdiv);
    chk("lit_hold_run", int'(gs_a), 1);
    START = 1'b0;

    frames(12);
    settle();
    chk("lit_score12_a", int'(score_a), 16'h0003);
    chk("lit_score12_b", int'(score_b), 16'h0012);

    frame(3, 1'b1, 1'b0);
    settle();
    chk("lit_ovl3_run", int'(gs_a), 1);
    frame(6, 1'b0, 1'b0);
    settle();
    chk("lit_novid_run", int'(gs_a), 1);
    for (int i = 0; i < 10; i++) frame(0, 1'b1, 1'b1);
    settle();
    chk("lit_ontick_run", int'(gs_a), 1);

    frame(4, 1'b1, 1'b0);
    settle();
    chk("lit_hit_over", int'(go_a), 1);
    chk("lit_hit_status", int'(gs_a), 0);
    chk("lit_hit_pulse", int'(hit_a), 1);
    chk("lit_hit_hi_a", int'(hi_a), 16'h0006);
    chk("lit_hit_hi_b", int'(hi_b), 16'h0024);
    settle();
    chk("lit_hit_drop", int'(hit_a), 0);

    press();
    chk("lit_restart_run", int'(gs_a), 1);
    chk("lit_restart_score", int'(score_a), 0);
    frames(48);
    frame(5, 1'b1, 1'b0);
    settle();
    chk("lit_g2_hi_a", int'(hi_a), 16'h0012);
    chk("lit_g2_hi_b", int'(hi_b), 16'h0048);

    // START pulse lands on the same edge as a frame tick.
    @(negedge clkdiv);
    START = 1'b1;
    fresh = 1'b1;
    @(negedge clkdiv);
    @(negedge clkdiv);
    fresh = 1'b0;
    settle();
    chk("lit_coin_run", int'(gs_a), 1);
    chk("lit_coin_score", int'(score_a), 0);
    chk("lit_coin_hi", int'(hi_a), 16'h0012);
    @(negedge clkdiv);
    START = 1'b0;
    frames(3);
    settle();
    chk("lit_coin_fc3", int'(score_a), 0);
    frames(1);
    settle();
    chk("lit_coin_fc4", int'(score_a), 1);
    frames(24);
    frame(4, 1'b1, 1'b0);
    settle();
    chk("lit_g3_score", int'(score_a), 16'h0007);
    chk("lit_g3_hi_a", int'(hi_a), 16'h0012);
    chk("lit_g3_hi_b", int'(hi_b), 16'h0048);

    press();
    frames(396);
    settle();
    chk("lit_pre_a", int'(score_a), 16'h0099);
    chk("lit_pre_b", int'(score_b), 16'h0396);
    frames(4);
    settle();
    chk("lit_carry_a", int'(score_a), 16'h0100);
    chk("lit_carry_b", int'(score_b), 16'h0400);
    frames(9599);
    settle();
    chk("lit_top_b", int'(score_b), 16'h9999);
    frames(8);
    settle();
    chk("lit_sat_b", int'(score_b), 16'h9999);
    chk("lit_sat_a", int'(score_a), 16'h2501);

    // Asynchronous reset in the middle of a run.
    @(negedge clkdiv);
    #2;
    RESET = 1'b1;
    #1;
    chk("lit_arst_status", int'(gs_a), 0);
    chk("lit_arst_over", int'(go_b), 0);
    chk("lit_arst_score", int'(score_a), 0);
    chk("lit_arst_hi", int'(hi_b), 0);
    @(negedge clkdiv);
    RESET = 1'b0;
    repeat (3) @(negedge clkdiv);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
